exe_mdu: RTL

//  Parametrised iterative multiply/divide unit for the EXE stage; supports MUL.W, MULH.W,

---
 rtl/exe_mdu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/exe_mdu.sv
// Iterative multiply/divide unit for the EXE stage: shift-add multiply, restoring divide,
// valid/ready on both sides, pass-through writeback tag and a global flush.
module exe_mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dsr,
  output logic [XLEN-1:0] nrem,
  output logic [XLEN-1:0] nquo
);
  logic [XLEN:0] part, diff;
  logic          ge;

  // rem < dsr always holds, so part fits XLEN+1 bits and diff's MSB is the borrow.
  assign part = {rem, quo[XLEN-1]};
  assign diff = part - {1'b0, dsr};
  assign ge   = ~diff[XLEN];
  assign nrem = ge ? diff[XLEN-1:0] : part[XLEN-1:0];
  assign nquo = {quo[XLEN-2:0], ge};
endmodule

module exe_mdu #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2,
  parameter int DIV_BPC = 1,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             busy
);
  localparam int MUL_N = XLEN / MUL_BPC;
  localparam int DIV_N = XLEN / DIV_BPC;
  localparam int MAX_N = (MUL_N > DIV_N) ? MUL_N : DIV_N;
  localparam int CNT_W = $clog2(MAX_N) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef struct packed {
    logic is_div;
    logic sgn;
    logic sel_hi;
    logic sel_rem;
  } dec_t;

  // Reserved op 7 decodes exactly like MUL.
  function automatic dec_t decode(input logic [2:0] op);
    dec_t d;
    d.is_div  = op inside {3'd3, 3'd4, 3'd5, 3'd6};
    d.sgn     = op inside {3'd0, 3'd1, 3'd3, 3'd4, 3'd7};
    d.sel_hi  = op inside {3'd1, 3'd2};
    d.sel_rem = op inside {3'd4, 3'd6};
    return d;
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  a_q, hi_q, lo_q;
  logic [TAG_W-1:0] tag_q;
  logic             div_q, sel_hi_q, sel_rem_q, neg_q, neg_r;

  dec_t dec_in;
  logic s1, s2, accept;
  assign dec_in = decode(in_op);
  assign s1     = dec_in.sgn & in_src1[XLEN-1];
  assign s2     = dec_in.sgn & in_src2[XLEN-1];

  assign in_ready  = ((state == IDLE) | ((state == DONE) & out_ready)) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Multiply step: {hi,lo} holds partial product above the unconsumed multiplier bits.
  logic [XLEN+MUL_BPC-1:0] mul_sum;
  logic [XLEN-1:0]         mul_hi, mul_lo;
  assign mul_sum = {{MUL_BPC{1'b0}}, hi_q} +
                   ({{MUL_BPC{1'b0}}, a_q} * {{XLEN{1'b0}}, lo_q[MUL_BPC-1:0]});
  assign mul_hi  = mul_sum[XLEN+MUL_BPC-1:MUL_BPC];
  assign mul_lo  = {mul_sum[MUL_BPC-1:0], lo_q[XLEN-1:MUL_BPC]};

  // Divide: DIV_BPC restoring steps chained per cycle; hi = remainder, lo = quotient.
  logic [XLEN-1:0] rem_c [DIV_BPC+1];
  logic [XLEN-1:0] quo_c [DIV_BPC+1];
  assign rem_c[0] = hi_q;
  assign quo_c[0] = lo_q;
  for (genvar i = 0; i < DIV_BPC; i++) begin : g_div
    exe_mdu_div_step #(.XLEN(XLEN)) u_step (
      .rem (rem_c[i]),
      .quo (quo_c[i]),
      .dsr (a_q),
      .nrem(rem_c[i+1]),
      .nquo(quo_c[i+1])
    );
  end

  logic [XLEN-1:0]   nxt_hi, nxt_lo, quo_s, rem_s, fin;
  logic [2*XLEN-1:0] prod, prod_s;
  assign nxt_hi = (state == DIV) ? rem_c[DIV_BPC] : mul_hi;
  assign nxt_lo = (state == DIV) ? quo_c[DIV_BPC] : mul_lo;
  assign prod   = {nxt_hi, nxt_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -nxt_lo : nxt_lo;
  assign rem_s  = neg_r ? -nxt_hi : nxt_hi;
  assign fin    = div_q    ? (sel_rem_q ? rem_s : quo_s)
                : sel_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      out_result <= '0;
      out_tag    <= '0;
      out_dbz    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      tag_q     <= in_tag;
      div_q     <= dec_in.is_div;
      sel_hi_q  <= dec_in.sel_hi;
      sel_rem_q <= dec_in.sel_rem;
      neg_q     <= s1 ^ s2;
      neg_r     <= s1;
      hi_q      <= '0;
      if (dec_in.is_div) begin
        a_q  <= mag(in_src2, dec_in.sgn);
        lo_q <= mag(in_src1, dec_in.sgn);
        cnt  <= CNT_W'(DIV_N - 1);
        if (in_src2 == '0) begin
          state      <= DONE;
          out_result <= dec_in.sel_rem ? in_src1 : '1;
          out_tag    <= in_tag;
          out_dbz    <= 1'b1;
        end else begin
          state <= DIV;
        end
      end else begin
        a_q   <= mag(in_src1, dec_in.sgn);
        lo_q  <= mag(in_src2, dec_in.sgn);
        cnt   <= CNT_W'(MUL_N - 1);
        state <= MUL;
      end
    end else begin
      case (state)
        MUL, DIV: begin
          hi_q <= nxt_hi;
          lo_q <= nxt_lo;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state      <= DONE;
            out_result <= fin;
            out_tag    <= tag_q;
            out_dbz    <= 1'b0;
          end
        end
        DONE:    if (out_ready) state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule
